// File: rtl/miner_pkg.sv
// miner_pkg: constants and types shared by the miner input path.
//   HDR_WORDS / WORD_W : block header geometry (20 x 32-bit words).
//   asm_state_t        : work assembler state encoding.
//   header_t           : one fully packed block header.
package miner_pkg;

  localparam int HDR_WORDS = 20;
  localparam int WORD_W    = 32;

  typedef enum logic {FILL, PRESENT} asm_state_t;

  typedef logic [HDR_WORDS*WORD_W-1:0] header_t;

endpackage

// File: rtl/work_assembler_stall_timer.sv
// stall_timer: loadable saturating up-counter with terminal-count pulse.
//   clk, rst  : clock, async active-high reset
//   clr       : synchronous clear (highest priority, also suppresses tc)
//   en        : count enable
//   load      : load load_val instead of counting
//   load_val  : value for load
//   tc        : combinational pulse in the cycle the count would reach LIMIT;
//               the counter returns to 0 on that edge. LIMIT=0 disables tc.
module stall_timer #(
  parameter int LIMIT = 1024,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  localparam bit             ENABLED = (LIMIT > 0);
  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] SAT_VAL = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    tc = ENABLED && en && !clr && !load && (cnt_q == TC_VAL);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != SAT_VAL)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/work_assembler.sv
// work_assembler: packs consecutive FWFT FIFO words into one wide work unit
// and hands it to the hash core over valid/ready.
//   clk, rst     : clock (FIFO rd_clk), async active-high reset
//   fifo_dout    : FWFT head word, valid while fifo_empty=0
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : pop the head word this cycle (combinational)
//   flush        : synchronous discard of partial or presented work
//   work_data    : assembled unit, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   work_valid   : work_data complete and stable
//   work_ready   : hash core accepts work
//   busy         : partial assembly in progress or work presented
//   timeout_err  : one-cycle pulse when a stalled partial unit is dropped
//   work_count   : accepted work units, wraps silently
//
// state   | meaning
// FILL    | popping words into slot idx
// PRESENT | unit complete, holding work_valid until accepted
module work_assembler
  import miner_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_W,
  parameter int WORDS_PER_WORK = HDR_WORDS,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [WORD_WIDTH-1:0]                fifo_dout,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rd_en,
  input  logic                                 flush,
  output logic [WORD_WIDTH*WORDS_PER_WORK-1:0] work_data,
  output logic                                 work_valid,
  input  logic                                 work_ready,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic [COUNT_WIDTH-1:0]               work_count
);

  localparam int IDX_W = (WORDS_PER_WORK > 1) ? $clog2(WORDS_PER_WORK) : 1;
  localparam int STALL_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_WORK - 1);

  asm_state_t                          state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [WORD_WIDTH*WORDS_PER_WORK-1:0] data_q, data_d;
  logic                                valid_q, valid_d;
  logic                                terr_q, terr_d;
  logic [COUNT_WIDTH-1:0]              count_q, count_d;

  logic rd_en;
  logic stall_en;
  logic stall_clr;
  logic stall_tc;

  // Gated by rst so the pop strobe drops the instant reset asserts,
  // not just at the next edge.
  always_comb begin
    rd_en = !rst && (state_q == FILL) && !fifo_empty && !flush;
  end

  // The stall timer only runs while a partial unit is waiting on an empty FIFO.
  always_comb begin
    stall_en  = (state_q == FILL) && (idx_q != '0) && fifo_empty;
    stall_clr = flush || rd_en || (state_q != FILL) || (idx_q == '0);
  end

  stall_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (STALL_W)
  ) u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (stall_clr),
    .en       (stall_en),
    .load     (1'b0),
    .load_val ('0),
    .tc       (stall_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    terr_d  = 1'b0;

    case (state_q)
      FILL: begin
        if (rd_en) begin
          for (int k = 0; k < WORDS_PER_WORK; k++) begin
            if (idx_q == IDX_W'(k)) begin
              data_d[k*WORD_WIDTH +: WORD_WIDTH] = fifo_dout;
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PRESENT;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (stall_tc) begin
          // Stale slots are left in place; the next fill overwrites them.
          idx_d  = '0;
          terr_d = 1'b1;
        end
      end
      PRESENT: begin
        if (valid_q && work_ready) begin
          count_d = count_q + COUNT_WIDTH'(1);
          valid_d = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // A handshake in the flush cycle still counts (count_d above is kept).
    if (flush) begin
      state_d = FILL;
      idx_d   = '0;
      valid_d = 1'b0;
      terr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    fifo_rd_en  = rd_en;
    work_data   = data_q;
    work_valid  = valid_q;
    timeout_err = terr_q;
    work_count  = count_q;
    busy        = (idx_q != '0) || valid_q;
  end

endmodule

// File: tb/tb_work_assembler.sv
module tb_work_assembler;

  localparam int W  = 32;
  localparam int N  = 20;
  localparam int TO = 8;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    fifo_dout;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic            flush = 1'b0;
  logic [W*N-1:0]  work_data;
  logic            work_valid;
  logic            work_ready = 1'b0;
  logic            busy;
  logic            timeout_err;
  logic [CW-1:0]   work_count;

  // Second instance with a 2-bit counter, driven identically, to see the wrap.
  logic            fifo_rd_en_s;
  logic [W*N-1:0]  work_data_s;
  logic            work_valid_s;
  logic            busy_s;
  logic            timeout_err_s;
  logic [1:0]      work_count_s;

  work_assembler #(.WORD_WIDTH(W), .WORDS_PER_WORK(N), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .flush(flush), .work_data(work_data), .work_valid(work_valid), .work_ready(work_ready),
    .busy(busy), .timeout_err(timeout_err), .work_count(work_count));

  work_assembler #(.WORD_WIDTH(W), .WORDS_PER_WORK(N), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_s),
    .flush(flush), .work_data(work_data_s), .work_valid(work_valid_s), .work_ready(work_ready),
    .busy(busy_s), .timeout_err(timeout_err_s), .work_count(work_count_s));

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  int           total = 0;    // reference count of accepted units since reset
  int           npops = 0;
  logic [W-1:0] q[$];         // FIFO model
  bit           hold_empty = 1'b0;
  logic         samp_rd;

  task automatic refresh();
    fifo_empty = hold_empty || (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : '0;
  endtask

  // One clock: sample the pop strobe mid-cycle, pop the model FIFO after the edge.
  task automatic tick();
    logic [W-1:0] dummy;
    @(negedge clk);
    samp_rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (samp_rd && q.size() > 0) begin
      dummy = q.pop_front();
      npops++;
    end
    refresh();
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    for (int i = 0; i < limit && !work_valid; i++) begin
      tick();
      cyc = i + 1;
    end
    if (!work_valid) cyc = -1;
  endtask

  function automatic logic [W*N-1:0] pack(input logic [W-1:0] w[$], input int base);
    logic [W*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = w[base+k];
    return r;
  endfunction

  task automatic push_rand(input int n, inout logic [W-1:0] w[$]);
    logic [W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      w.push_back(v);
      q.push_back(v);
    end
    refresh();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q.push_back(32'h0);
    refresh();
    #2;
    tests++; if (work_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", work_valid); end
    tests++; if (work_count !== 16'h0) begin fails++; $display("FAIL rst_count: got %h want 0", work_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    tests++; if (work_data !== '0) begin fails++; $display("FAIL rst_data: got %h want 0", work_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] w[$];
    for (int i = 0; i < N; i++) w.push_back(W'(i));
    for (int i = 1; i < N; i++) q.push_back(W'(i));
    work_ready = 1'b1;
    npops = 0;
    refresh();
    for (int i = 0; i < N; i++) begin
      tick();
      if (i == N - 2) begin
        tests++; if (work_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_early: got %b want 0", work_valid); end
      end
    end
    tests++; if (npops !== N) begin fails++; $display("FAIL basic_pops: got %0d want %0d", npops, N); end
    tests++; if (work_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_latency: got %b want 1", work_valid); end
    tests++; if (work_data[31:0] !== 32'h0) begin fails++; $display("FAIL basic_word0: got %h want 0", work_data[31:0]); end
    tests++; if (work_data[639:608] !== 32'h13) begin fails++; $display("FAIL basic_word19: got %h want 13", work_data[639:608]); end
    tests++; if (work_data !== pack(w, 0)) begin fails++; $display("FAIL basic_data: got %h want %h", work_data, pack(w, 0)); end
    tick();
    total++;
    tests++; if (work_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b want 0", work_valid); end
    tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL basic_count: got %0d want %0d", work_count, total); end
    tests++; if (work_count_s !== 2'(total)) begin fails++; $display("FAIL basic_count_s: got %0d want %0d", work_count_s, total % 4); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[$];
    logic [W*N-1:0] snap;
    int cyc, rd_err, st_err;
    work_ready = 1'b0;
    npops = 0;
    push_rand(2 * N, w);
    wait_valid(60, cyc);
    tests++; if (cyc !== N) begin fails++; $display("FAIL bp_latency: got %0d want %0d", cyc, N); end
    tests++; if (work_data !== pack(w, 0)) begin fails++; $display("FAIL bp_data0: got %h want %h", work_data, pack(w, 0)); end
    snap = work_data;
    rd_err = 0;
    st_err = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (samp_rd) rd_err++;
      if (work_data !== snap || work_valid !== 1'b1) st_err++;
    end
    tests++; if (rd_err !== 0) begin fails++; $display("FAIL bp_no_pop: got %0d pops want 0", rd_err); end
    tests++; if (st_err !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", st_err); end
    work_ready = 1'b1;
    tick();
    total++;
    tests++; if (samp_rd !== 1'b0) begin fails++; $display("FAIL bp_hs_pop: got %b want 0", samp_rd); end
    tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL bp_count1: got %0d want %0d", work_count, total); end
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL bp_first_pop: got %b want 1", fifo_rd_en); end
    wait_valid(40, cyc);
    tests++; if (cyc !== N) begin fails++; $display("FAIL bp_latency2: got %0d want %0d", cyc, N); end
    tests++; if (work_data !== pack(w, N)) begin fails++; $display("FAIL bp_data1: got %h want %h", work_data, pack(w, N)); end
    tick();
    total++;
    tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL bp_count2: got %0d want %0d", work_count, total); end
    tests++; if (work_count_s !== 2'(total)) begin fails++; $display("FAIL bp_count_s: got %0d want %0d", work_count_s, total % 4); end
  endtask

  task automatic test_timeout();
    logic [W-1:0] w[$];
    logic [W-1:0] w2[$];
    int pulses, at_k, cyc;
    work_ready = 1'b1;
    npops = 0;
    push_rand(5, w);
    for (int i = 0; i < 5; i++) tick();
    tests++; if (npops !== 5 || busy !== 1'b1) begin fails++; $display("FAIL to_partial: got pops %0d busy %b want 5 1", npops, busy); end
    pulses = 0;
    at_k = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (timeout_err === 1'b1) begin
        pulses++;
        if (at_k < 0) at_k = k;
      end
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    tests++; if (at_k !== TO) begin fails++; $display("FAIL to_delay: got %0d want %0d", at_k, TO); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", busy); end
    push_rand(N, w2);
    wait_valid(40, cyc);
    tests++; if (work_data[W-1:0] !== w2[0]) begin fails++; $display("FAIL to_slot0: got %h want %h", work_data[W-1:0], w2[0]); end
    tests++; if (work_data !== pack(w2, 0)) begin fails++; $display("FAIL to_data: got %h want %h", work_data, pack(w2, 0)); end
    tick();
    total++;
    tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL to_count: got %0d want %0d", work_count, total); end
  endtask

  task automatic test_flush();
    logic [W-1:0] w[$];
    int cyc, terr_seen;
    work_ready = 1'b1;
    npops = 0;
    terr_seen = 0;
    push_rand(N + 7, w);
    for (int i = 0; i < 7; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (timeout_err === 1'b1) terr_seen++;
    tests++; if (samp_rd !== 1'b0 || npops !== 7) begin fails++; $display("FAIL fl_no_pop: got rd %b pops %0d want 0 7", samp_rd, npops); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fl_idx_reset: got busy %b want 0", busy); end
    for (int i = 0; i < 40 && !work_valid; i++) begin
      tick();
      if (timeout_err === 1'b1) terr_seen++;
    end
    tests++; if (work_data !== pack(w, 7)) begin fails++; $display("FAIL fl_data: got %h want %h", work_data, pack(w, 7)); end
    tests++; if (terr_seen !== 0) begin fails++; $display("FAIL fl_terr: got %0d pulses want 0", terr_seen); end
    tick();
    total++;
    tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL fl_count: got %0d want %0d", work_count, total); end
    // Flush while presenting, first without and then with a handshake.
    work_ready = 1'b0;
    w.delete();
    push_rand(N, w);
    wait_valid(40, cyc);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++; if (work_valid !== 1'b0 || work_count !== CW'(total)) begin fails++; $display("FAIL fl_present: got valid %b count %0d want 0 %0d", work_valid, work_count, total); end
    w.delete();
    push_rand(N, w);
    wait_valid(40, cyc);
    tests++; if (work_data !== pack(w, 0)) begin fails++; $display("FAIL fl_refill: got %h want %h", work_data, pack(w, 0)); end
    work_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    tests++; if (work_valid !== 1'b0 || work_count !== CW'(total)) begin fails++; $display("FAIL fl_hs: got valid %b count %0d want 0 %0d", work_valid, work_count, total); end
    tests++; if (work_count_s !== 2'(total)) begin fails++; $display("FAIL fl_count_s: got %0d want %0d", work_count_s, total % 4); end
  endtask

  task automatic test_random();
    logic [W-1:0] w[$];
    int run, dly, err, cyc;
    for (int u = 0; u < 6; u++) begin
      w.delete();
      push_rand(N, w);
      run = 0;
      cyc = 0;
      while (!work_valid && cyc < 300) begin
        hold_empty = ($urandom_range(0, 2) == 0) && (run < 3);
        run = hold_empty ? run + 1 : 0;
        work_ready = $urandom_range(0, 1) == 1;
        tick();
        cyc++;
      end
      hold_empty = 1'b0;
      work_ready = 1'b0;
      refresh();
      tests++; if (work_valid !== 1'b1 || work_data !== pack(w, 0)) begin fails++; $display("FAIL rnd_data%0d: got v %b %h want %h", u, work_valid, work_data, pack(w, 0)); end
      tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL rnd_ready_ignored%0d: got %0d want %0d", u, work_count, total); end
      dly = $urandom_range(0, 3);
      err = 0;
      for (int d = 0; d < dly; d++) begin
        tick();
        if (samp_rd || !work_valid) err++;
      end
      work_ready = 1'b1;
      tick();
      total++;
      tests++; if (err !== 0 || work_valid !== 1'b0 || work_count !== CW'(total) || work_count_s !== 2'(total)) begin
        fails++; $display("FAIL rnd_hs%0d: got err %0d v %b cnt %0d/%0d want 0 0 %0d", u, err, work_valid, work_count, work_count_s, total);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w[$];
    logic [W-1:0] dummy[$];
    int cyc;
    work_ready = 1'b0;
    push_rand(N, dummy);
    wait_valid(40, cyc);
    push_rand(5, w);
    #2;
    rst = 1'b1;
    #1;
    total = 0;
    tests++; if (work_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin fails++; $display("FAIL ar_outputs: got valid %b rd %b want 0 0", work_valid, fifo_rd_en); end
    tests++; if (work_count !== 16'h0 || work_count_s !== 2'h0 || busy !== 1'b0) begin fails++; $display("FAIL ar_count: got %0d %0d busy %b want 0 0 0", work_count, work_count_s, busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_rand(N - 5, w);
    wait_valid(40, cyc);
    tests++; if (cyc !== N || work_data !== pack(w, 0)) begin fails++; $display("FAIL ar_restart: got cyc %0d %h want %0d %h", cyc, work_data, N, pack(w, 0)); end
    work_ready = 1'b1;
    tick();
    total++;
    tests++; if (work_count !== CW'(total)) begin fails++; $display("FAIL ar_count_after: got %0d want %0d", work_count, total); end
  endtask

  initial begin
    refresh();
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/work_assembler.md
Name: work_assembler

Overview:
- Sits on the read side of the miner's input clock-crossing FIFO (FWFT mode, 32-bit, rd_clk domain).
- Pops consecutive 32-bit words, packs WORDS_PER_WORK of them into one wide work unit (an 80-byte block header by default), and presents it to the hash core over a valid/ready handshake.
- Discards stalled partial work after a timeout, supports a synchronous flush, and keeps a count of delivered work units.

Parameters:
- WORD_WIDTH, 32, width of one FIFO word.
- WORDS_PER_WORK, 20, words per work unit (20 x 32 = 640-bit header).
- TIMEOUT_CYCLES, 1024, maximum consecutive empty cycles allowed mid-assembly; 0 disables the timeout.
- COUNT_WIDTH, 16, width of the delivered-work counter.

Ports:
- clk  in  1  single clock; same clock as the FIFO rd_clk.
- rst  in  1  reset, asynchronous, active-high.
- fifo_dout  in  WORD_WIDTH  FWFT head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pops the head word in this cycle.
- flush  in  1  synchronous discard of partial or presented work.
- work_data  out  WORD_WIDTH*WORDS_PER_WORK  assembled unit; word k at bits [k*WORD_WIDTH +: WORD_WIDTH].
- work_valid  out  1  work_data is complete and stable.
- work_ready  in  1  hash core accepts work.
- busy  out  1  idx>0 or work_valid.
- timeout_err  out  1  one-cycle pulse when partial work is discarded by timeout.
- work_count  out  COUNT_WIDTH  number of accepted work units; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state=FILL, idx=0, stall counter=0.
  - work_data=0, work_valid=0, fifo_rd_en=0, timeout_err=0, work_count=0, busy=0.
  - FIFO contents are not touched; the FIFO has its own reset.
- fifo_rd_en is combinational: (state==FILL) && !fifo_empty && !flush. It is never asserted in PRESENT.
- FILL state:
  - On each fifo_rd_en cycle, fifo_dout is captured into word slot idx and idx increments.
  - When the word captured has idx==WORDS_PER_WORK-1: idx returns to 0 and the next state is PRESENT.
  - work_valid=1 from the cycle after the last pop. Latency from last pop to valid is 1 clk.
  - Minimum period per work unit is WORDS_PER_WORK+1 cycles when the FIFO is never empty and work_ready is held high.
- PRESENT state:
  - work_data and work_valid are held stable until work_valid && work_ready.
  - On that handshake: work_count increments, work_valid drops next cycle, state returns to FILL.
  - The first pop of the next unit occurs in the cycle after the handshake.
- Timeout:
  - Applies only in FILL with idx>0.
  - The stall counter increments on each cycle with fifo_empty=1 and clears on any pop.
  - When it reaches TIMEOUT_CYCLES: idx=0, the counter clears, and timeout_err pulses for one cycle.
  - work_data is not cleared; stale slots are overwritten by the next fill.
  - There is no timeout when idx==0 or in PRESENT.
- Flush:
  - From any state, the next cycle has state=FILL, idx=0, stall counter cleared, work_valid=0.
  - No timeout_err pulse.
  - fifo_rd_en is gated off in the flush cycle, so no word is lost mid-flight.
  - Flush together with a handshake in the same cycle: the handshake counts (work_count increments), then the flush effect applies.
- Simultaneous events:
  - A pop that completes a unit and a timeout in the same cycle cannot occur, because a pop clears the stall counter.
  - work_ready while work_valid=0 is ignored.
- Width rules:
  - idx width is $clog2(WORDS_PER_WORK).
  - The stall counter width is $clog2(TIMEOUT_CYCLES+1).
  - The work_count wrap from all-ones to 0 is silent.

Decomposition:
- Shared package miner_pkg holds:
  - constants HDR_WORDS=20 and WORD_W=32;
  - typedef enum logic {FILL, PRESENT} asm_state_t;
  - typedef logic [HDR_WORDS*WORD_W-1:0] header_t.
- One sub-module is natural: stall_timer, a loadable saturating counter with clear, enable and a terminal-count pulse, reused for the timeout.

Test Plan:
- FIFO preloaded with words 0x00000000..0x00000013, work_ready=1:
  - 20 consecutive fifo_rd_en pulses;
  - work_valid rises 1 cycle after the 20th pop;
  - work_data[31:0]=0x0, work_data[639:608]=0x13;
  - work_count=1 after the handshake.
- 40 words preloaded, work_ready held 0 for 10 cycles after the first valid:
  - fifo_rd_en stays 0 and work_data is stable throughout;
  - after ready, the second unit's first pop is exactly 1 cycle post-handshake.
- TIMEOUT_CYCLES=8, feed 5 words then stay empty:
  - timeout_err pulses once, 8 cycles after the 5th pop;
  - busy=0 afterwards;
  - a subsequent 20 words produce a correct unit with the new word 0 in slot 0.
- flush asserted after 7 words with the FIFO non-empty:
  - no pop in the flush cycle;
  - idx resets;
  - the next 20 popped words form the unit;
  - timeout_err stays 0.
- rst asserted mid-PRESENT, asynchronously between clock edges:
  - work_valid, fifo_rd_en and work_count go to 0 immediately;
  - after release, assembly restarts at slot 0.
- Force work_count to 0xFFFF, complete one unit: work_count=0x0000.
